// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake, registered result and N/Z/C/V flags.
// Ports:
//   CLK, Reset_L          clock (rising edge), asynchronous active-low reset
//   BusA, BusB            operands; shift amount is BusB[$clog2(N)-1:0]
//   ALUCtrl               opcode: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111,
//                         LSL 0011, LSR 0100, MUL 1000
//   in_valid / in_ready   operand handshake
//   BusW, Zero, Negative, Carry, Overflow   registered result and flags
//   out_valid / out_ready result handshake
// Build option: SEQ_ALU_MUL_EN compiles in the iterative shift-add multiplier;
// without it opcode 1000 completes like any undefined opcode.
module seq_alu #(
    parameter int N = 64
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    input  logic [3:0]   ALUCtrl,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Negative,
    output logic         Carry,
    output logic         Overflow,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE, MUL, DONE} stateT;
    stateT state;

    logic [N-1:0] res;
    logic         resC;
    logic         resV;
    logic [N:0]   addW;
    logic [N:0]   subW;
    logic [SW-1:0] shamt;

    assign shamt = BusB[SW-1:0];
    assign addW  = {1'b0, BusA} + {1'b0, BusB};
    // Subtraction as A + ~B + 1 so the carry-out directly means "no borrow".
    assign subW  = {1'b0, BusA} + {1'b0, ~BusB} + {{N{1'b0}}, 1'b1};

    assign in_ready  = (state == IDLE) & Reset_L;
    assign out_valid = (state == DONE);

    always_comb begin
        res  = '0;
        resC = 1'b0;
        resV = 1'b0;
        case (ALUCtrl)
            4'b0000: res = BusA & BusB;
            4'b0001: res = BusA | BusB;
            4'b0010: begin
                res  = addW[N-1:0];
                resC = addW[N];
                resV = (BusA[N-1] == BusB[N-1]) && (addW[N-1] != BusA[N-1]);
            end
            4'b0110: begin
                res  = subW[N-1:0];
                resC = subW[N];
                resV = (BusA[N-1] != BusB[N-1]) && (subW[N-1] != BusA[N-1]);
            end
            4'b0111: res = BusB;
            4'b0011: res = BusA << shamt;
            4'b0100: res = BusA >> shamt;
            default: res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic [N-1:0]  acc;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [N-1:0]  accNext;
    logic [SW-1:0] cnt;

    assign accNext = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            BusW     <= '0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    if (ALUCtrl == 4'b1000) begin
                        acc    <= '0;
                        mcand  <= BusA;
                        mplier <= BusB;
                        cnt    <= '0;
                        state  <= MUL;
                    end else
`endif
                    begin
                        BusW     <= res;
                        Zero     <= (res == '0);
                        Negative <= res[N-1];
                        Carry    <= resC;
                        Overflow <= resV;
                        state    <= DONE;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                // Fixed N iterations; the last one writes the sum straight to BusW.
                MUL: begin
                    acc    <= accNext;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SW'(N - 1)) begin
                        BusW     <= accNext;
                        Zero     <= (accNext == '0);
                        Negative <= accNext[N-1];
                        Carry    <= 1'b0;
                        Overflow <= 1'b0;
                        state    <= DONE;
                    end
                end
`endif
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. It accepts one operation at a time over a valid/ready handshake and returns a registered result with N/Z/C/V flags. Single-cycle ops (AND/OR/ADD/SUB/PassB/LSL/LSR) complete in one cycle; MUL runs as an iterative shift-add. It sits between the execute-stage operand latches and the writeback mux of the multicycle datapath.

## Interface
- N, default 64, datapath width; must be a power of two, at least 8.
- CLK  input  1  clock; all state changes on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- BusA  input  N  operand A.
- BusB  input  N  operand B; the shift amount is BusB[$clog2(N)-1:0].
- ALUCtrl  input  4  opcode:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PassB.
  - 0011 LSL, 0100 LSR, 1000 MUL.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept; equals (state==IDLE) & Reset_L.
- BusW  output  N  registered result.
- Zero, Negative, Carry, Overflow  output  1 each  registered flags.
- out_valid  output  1  BusW and the flags are valid.
- out_ready  input  1  consumer accepts the result.

## Operation
- FSM states: IDLE, MUL, DONE.
  - IDLE: on accept (in_valid & in_ready), latch the operands and the opcode.
    - Single-cycle op: compute, register BusW and the flags, go to DONE.
    - MUL: load acc=0, mcand=BusA, mplier=BusB, cnt=0, go to MUL.
  - MUL: each cycle, if mplier[0] then acc += mcand.
    - mcand <<= 1; mplier >>= 1; cnt++.
    - When cnt reaches N-1 (the Nth iteration), register BusW = low N bits of the sum and go to DONE.
  - DONE: out_valid=1; BusW and the flags stay stable until out_ready=1.
    - Then return to IDLE. A result and a new operand are never accepted in the same cycle.
- Arithmetic (all modulo 2^N):
  - ADD: Carry = carry-out of bit N-1; Overflow = signed overflow.
  - SUB: computed as A + ~B + 1; Carry = 1 when A >= B unsigned (no borrow); Overflow = signed overflow.
  - AND, OR, PassB, LSL, LSR, MUL: Carry=0, Overflow=0.
  - LSL/LSR are logical; a shift amount of 0 passes A unchanged.
- Zero = (BusW==0) and Negative = BusW[N-1], both registered together with BusW.
- An undefined opcode completes in a single cycle with BusW=0, Zero=1 and the other flags 0.
- Operand inputs are ignored outside the accept cycle; changing BusA/BusB mid-MUL has no effect.

## Timing
- Reset (Reset_L low, asynchronous) forces:
  - state=IDLE;
  - BusW=0, Zero=0, Negative=0, Carry=0, Overflow=0, out_valid=0;
  - in_ready=0 while Reset_L is low.
- Reset asserted mid-MUL or in DONE aborts the operation; the result is lost.
- Single-cycle op: accept at edge k, out_valid=1 after edge k+1 (latency 1).
- MUL: accept at edge k, out_valid=1 after edge k+N (fixed; no early termination).
- DONE with out_ready=1 at edge j: out_valid=0 and in_ready=1 after edge j.
  - Maximum throughput is one single-cycle op every 2 cycles.
- out_ready held high in advance: DONE lasts exactly one cycle.
- out_ready is ignored outside DONE.

## Configuration
- SEQ_ALU_MUL_EN:
  - Defined: the MUL state, the accumulator and the counter are compiled in; opcode 1000 behaves as above.
  - Undefined: no multiplier hardware or MUL state; opcode 1000 is treated as an undefined opcode (1-cycle, BusW=0, Zero=1).

## Test plan
- Reset mid-MUL:
  - N=64; start MUL 7*9, pull Reset_L low at cycle 10.
  - Required: all outputs 0 immediately and in_ready=0 during reset.
  - After release: in_ready=1, and a new ADD completes normally.
- ADD carry/overflow:
  - N=64, ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> BusW=0x8000_0000_0000_0000, Negative=1, Overflow=1, Carry=0, out_valid one cycle after accept.
  - ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> BusW=0, Zero=1, Carry=1.
- SUB flags:
  - SUB 5-5 -> Zero=1, Carry=1.
  - SUB 3-5 -> BusW=0xFFFF_FFFF_FFFF_FFFE, Negative=1, Carry=0, Overflow=0.
- Shifts:
  - N=64, LSL 1 by BusB=63 -> 0x8000_0000_0000_0000.
  - LSR 0x8000_0000_0000_0000 by BusB=0x41 (amount 1) -> 0x4000_0000_0000_0000.
- MUL (SEQ_ALU_MUL_EN defined):
  - 12345 * 678 -> 8369910 exactly 64 cycles after accept.
  - 0xFFFF_FFFF_FFFF_FFFF * 2 -> 0xFFFF_FFFF_FFFF_FFFE.
  - Without the macro: MUL -> BusW=0, Zero=1 after 1 cycle.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after an OR result; BusW and the flags stay stable and in_ready=0 throughout.
  - Raise out_ready: in_ready=1 next cycle; the in_valid held meanwhile is accepted only then.
